stereo_matrix_gain: RTL and testbench
=====================================

Name: stereo_matrix_gain

Overview:
- Parametrised successor to the stereo sum/difference gain stage of the FM stereo modulator.
- Once per audio sample strobe, computes the sum (L+R) and difference (L−R) channels and scales each by a programmable unsigned gain using two sequential shift-add multipliers.
- Each result is saturated to NBITS and delivered with a valid pulse.
- Adds real saturation, a mono mode, overrun detection and a busy/valid handshake toward the pilot/subcarrier mixer.

Parameters:
- NBITS, 18, audio sample width (signed two's complement, in and out)
- K_NBITS, 4, gain word width (unsigned)
- K_FRAC, 3, fractional bits of the gain; gain 2^K_FRAC is unity on (L+R)/2

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enableclk  in  1  sample strobe, one-cycle pulse
- LEFTin  in  NBITS  signed left sample
- RIGHTin  in  NBITS  signed right sample
- Ks  in  K_NBITS  unsigned sum-channel gain
- Kd  in  K_NBITS  unsigned difference-channel gain
- mono  in  1  1 = force difference channel to zero
- clr_overrun  in  1  synchronous clear of the overrun flag
- SUMout  out  NBITS  signed scaled sum
- DIFout  out  NBITS  signed scaled difference
- valid_out  out  1  one-cycle pulse, new SUMout/DIFout
- clip_sum  out  1  SUMout saturated (qualified by valid_out)
- clip_dif  out  1  DIFout saturated (qualified by valid_out)
- busy  out  1  high whenever state != IDLE
- overrun  out  1  sticky: strobe arrived while busy

Behaviour:
- Reset (async, any time, including mid-operation): state IDLE; all outputs and internal registers 0. An in-flight sample is discarded and produces no valid_out.
- FSM states: IDLE, MUL, SAT.
- IDLE
  - enableclk=1 captures the following on that edge:
    - S = LEFTin+RIGHTin, width NBITS+1, no overflow
    - D = LEFTin−RIGHTin, width NBITS+1 (forced to 0 if mono=1)
    - Ks, Kd
  - Bit counter cleared; next state MUL.
- MUL
  - One gain bit per cycle, LSB first.
  - Accumulators P_s and P_d are signed, width NBITS+K_NBITS+1; each adds the left-shifted S/D when the current gain bit is 1.
  - Exactly K_NBITS cycles, then SAT.
- SAT
  - Y = P >>> (K_FRAC+1), arithmetic shift, i.e. floor toward −inf.
  - If Y > 2^(NBITS−1)−1: output max, clip=1. If Y < −2^(NBITS−1): output min, clip=1. Otherwise output Y, clip=0.
  - Registers SUMout, DIFout, clip_sum, clip_dif; valid_out=1 for one cycle; next state IDLE.
- Latency: strobe in cycle t gives valid_out high in cycle t+K_NBITS+2. Minimum strobe spacing is K_NBITS+2 cycles.
- A strobe in the same cycle valid_out is high is accepted (state is IDLE then).
- Strobe while busy (MUL or SAT): ignored, in-flight sample unaffected, overrun set to 1 on that edge.
- overrun
  - Cleared by clr_overrun.
  - If clr_overrun and a busy-strobe coincide, set wins.
- Inputs are sampled only at the capture edge; changes to LEFTin/RIGHTin/Ks/Kd/mono during MUL have no effect.
- SUMout/DIFout/clip flags hold their values between valid pulses.
- Gain 0 yields 0, clip=0.

Decomposition:
- Shared package stereo_pkg holds:
  - localparams for derived widths: SUMW = NBITS+1, PRODW = NBITS+K_NBITS+1
  - state encoding constants IDLE/MUL/SAT
  - the saturation bounds as functions of NBITS
- One sub-module, shiftadd_mult (signed multiplicand × unsigned multiplier, start/busy, K_NBITS-cycle), instantiated twice.
- FSM, capture and saturation stay in the top.

Test Plan:
- Unity gain, NBITS=18, K_NBITS=4: L=1000, R=200, Ks=Kd=8, strobe at t → valid_out only at t+6, SUMout=600, DIFout=400, clips 0, busy high t+1..t+5.
- Positive saturation: L=R=131071, Ks=15, Kd=15 → SUMout=131071 with clip_sum=1; DIFout=0 with clip_dif=0.
- Negative saturation and floor:
  - L=R=−131072, Ks=15 → SUMout=−131072, clip_sum=1.
  - Separate sample L=−3, R=0, Ks=Kd=1 → SUMout=−1, DIFout=−1.
- Overrun and back-to-back:
  - Strobes at t and t+2 → single valid at t+6 with the first sample's result, overrun=1.
  - Strobe at t+6 → accepted, valid at t+12.
  - clr_overrun → overrun=0.
- Mono and input isolation: mono=1, L=5000, R=−5000, Ks=Kd=8, LEFTin changed to 0 during MUL → SUMout=0, DIFout=0, clip_dif=0.
- Reset mid-operation: assert reset at t+3 (asynchronously, mid-cycle) → all outputs 0 immediately, no valid_out afterward, next strobe processed normally.

Source files
------------

// File: rtl/stereo_pkg.sv
// Shared definitions for the stereo sum/difference gain stage:
// default sizes, derived widths, FSM encoding and saturation bounds.
package stereo_pkg;

  localparam int NBITS_DEF   = 18;
  localparam int K_NBITS_DEF = 4;
  localparam int K_FRAC_DEF  = 3;

  // Width of L+R / L-R: one extra bit so the sum can never overflow.
  function automatic int sum_w(input int nbits);
    return nbits + 1;
  endfunction

  // Width of the gain product: sum width plus the gain word width.
  function automatic int prod_w(input int nbits, input int k_nbits);
    return nbits + k_nbits + 1;
  endfunction

  localparam int SUMW  = sum_w(NBITS_DEF);
  localparam int PRODW = prod_w(NBITS_DEF, K_NBITS_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    SAT  = 2'd2
  } state_e;

  // Largest positive value of an nbits-wide two's complement word.
  function automatic longint sat_max(input int nbits);
    return (longint'(1) << (nbits - 1)) - 1;
  endfunction

  // Most negative value of an nbits-wide two's complement word.
  function automatic longint sat_min(input int nbits);
    return -(longint'(1) << (nbits - 1));
  endfunction

endpackage

// File: rtl/shiftadd_mult.sv
// Sequential signed x unsigned multiplier: one multiplier bit per cycle,
// LSB first, B_W cycles after a start pulse. p_o holds the finished
// product from the cycle after done_o until the next start.
module shiftadd_mult #(
  parameter int A_W = 19,
  parameter int B_W = 4,
  parameter int P_W = 23
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic signed [A_W-1:0] a_i,
  input  logic        [B_W-1:0] b_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic signed [P_W-1:0] p_o
);

  localparam int CW = (B_W > 1) ? $clog2(B_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(B_W - 1);

  logic signed [P_W-1:0] mcand_q, mcand_d;
  logic signed [P_W-1:0] acc_q,   acc_d;
  logic        [B_W-1:0] mplier_q, mplier_d;
  logic        [CW-1:0]  cnt_q,   cnt_d;
  logic                  busy_q,  busy_d;

  // Load operands on start, then add the shifted multiplicand per set bit.
  always_comb begin
    // NOTE: every next-state signal takes its current value first, so no
    // path through this block leaves it unassigned and no latch is inferred.
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start_i) begin
      mcand_d  = P_W'(a_i);
      acc_d    = '0;
      mplier_d = b_i;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q <<< 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == LAST) busy_d = 1'b0;
    end
  end

  // Datapath and control registers.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples the pre-edge values, independent of statement order.
    if (reset) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == LAST);
  assign p_o    = acc_q;

endmodule

// File: rtl/stereo_matrix_gain.sv
// Stereo matrix gain stage: per sample strobe forms L+R and L-R, scales
// each by an unsigned fixed-point gain (unity = 2^K_FRAC on (L+R)/2),
// saturates to NBITS and presents the pair with a one-cycle valid pulse.
module stereo_matrix_gain
  import stereo_pkg::*;
#(
  parameter int NBITS   = NBITS_DEF,
  parameter int K_NBITS = K_NBITS_DEF,
  parameter int K_FRAC  = K_FRAC_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enableclk,
  input  logic signed [NBITS-1:0] LEFTin,
  input  logic signed [NBITS-1:0] RIGHTin,
  input  logic      [K_NBITS-1:0] Ks,
  input  logic      [K_NBITS-1:0] Kd,
  input  logic                    mono,
  input  logic                    clr_overrun,
  output logic signed [NBITS-1:0] SUMout,
  output logic signed [NBITS-1:0] DIFout,
  output logic                    valid_out,
  output logic                    clip_sum,
  output logic                    clip_dif,
  output logic                    busy,
  output logic                    overrun
);

  localparam int SW = sum_w(NBITS);
  localparam int PW = prod_w(NBITS, K_NBITS);

  localparam logic signed [PW-1:0]    Y_MAX   = PW'(sat_max(NBITS));
  localparam logic signed [PW-1:0]    Y_MIN   = PW'(sat_min(NBITS));
  localparam logic signed [NBITS-1:0] OUT_MAX = NBITS'(sat_max(NBITS));
  localparam logic signed [NBITS-1:0] OUT_MIN = NBITS'(sat_min(NBITS));

  state_e state_q, state_d;

  logic signed [NBITS-1:0] sum_q, sum_d, dif_q, dif_d;
  logic                    clip_s_q, clip_s_d, clip_d_q, clip_d_d;
  logic                    valid_q, valid_d, overrun_q, overrun_d;

  logic signed [SW-1:0] s_in, d_in;
  logic signed [PW-1:0] p_s, p_d, y_s, y_d;
  logic                 s_busy, d_busy, s_done, d_done, start;

  // Sum/difference of the live inputs; captured by the multipliers on start.
  always_comb begin
    s_in = SW'(LEFTin) + SW'(RIGHTin);
    d_in = mono ? '0 : SW'(LEFTin) - SW'(RIGHTin);
  end

  assign start = (state_q == IDLE) && enableclk && !s_busy && !d_busy;

  shiftadd_mult #(.A_W(SW), .B_W(K_NBITS), .P_W(PW)) u_mult_sum (
    .clock   (clock),
    .reset   (reset),
    .start_i (start),
    .a_i     (s_in),
    .b_i     (Ks),
    .busy_o  (s_busy),
    .done_o  (s_done),
    .p_o     (p_s)
  );

  shiftadd_mult #(.A_W(SW), .B_W(K_NBITS), .P_W(PW)) u_mult_dif (
    .clock   (clock),
    .reset   (reset),
    .start_i (start),
    .a_i     (d_in),
    .b_i     (Kd),
    .busy_o  (d_busy),
    .done_o  (d_done),
    .p_o     (p_d)
  );

  // Remove the gain fraction and the implicit /2; >>> floors toward -inf.
  assign y_s = p_s >>> (K_FRAC + 1);
  assign y_d = p_d >>> (K_FRAC + 1);

  // Next state, output capture with saturation, and the sticky overrun flag.
  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    dif_d     = dif_q;
    clip_s_d  = clip_s_q;
    clip_d_d  = clip_d_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q;

    unique case (state_q)
      IDLE: if (start) state_d = MUL;
      MUL:  if (s_done && d_done) state_d = SAT;
      SAT: begin
        state_d = IDLE;
        valid_d = 1'b1;
        if (y_s > Y_MAX) begin
          sum_d = OUT_MAX; clip_s_d = 1'b1;
        end else if (y_s < Y_MIN) begin
          sum_d = OUT_MIN; clip_s_d = 1'b1;
        end else begin
          sum_d = y_s[NBITS-1:0]; clip_s_d = 1'b0;
        end
        if (y_d > Y_MAX) begin
          dif_d = OUT_MAX; clip_d_d = 1'b1;
        end else if (y_d < Y_MIN) begin
          dif_d = OUT_MIN; clip_d_d = 1'b1;
        end else begin
          dif_d = y_d[NBITS-1:0]; clip_d_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // A strobe during a busy cycle beats a simultaneous clear.
    if (enableclk && (state_q != IDLE)) overrun_d = 1'b1;
    else if (clr_overrun)               overrun_d = 1'b0;
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sum_q     <= '0;
      dif_q     <= '0;
      clip_s_q  <= 1'b0;
      clip_d_q  <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      dif_q     <= dif_d;
      clip_s_q  <= clip_s_d;
      clip_d_q  <= clip_d_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign SUMout    = sum_q;
  assign DIFout    = dif_q;
  assign clip_sum  = clip_s_q;
  assign clip_dif  = clip_d_q;
  assign valid_out = valid_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_stereo_matrix_gain.sv
// Scoreboard bench for stereo_matrix_gain: stimulus pushes hand-computed
// results with their due cycle; a negedge monitor pops on every valid_out.
module tb_stereo_matrix_gain;

  localparam int NBITS   = 18;
  localparam int K_NBITS = 4;
  localparam int K_FRAC  = 3;
  localparam int LAT     = K_NBITS + 1;  // capture edge to valid edge

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    enableclk;
  logic signed [NBITS-1:0] LEFTin, RIGHTin;
  logic      [K_NBITS-1:0] Ks, Kd;
  logic                    mono, clr_overrun;
  logic signed [NBITS-1:0] SUMout, DIFout;
  logic                    valid_out, clip_sum, clip_dif, busy, overrun;

  typedef struct {
    longint sum;
    longint dif;
    bit     cs;
    bit     cd;
    int     cyc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  stereo_matrix_gain #(.NBITS(NBITS), .K_NBITS(K_NBITS), .K_FRAC(K_FRAC)) dut (
    .clock       (clock),
    .reset       (reset),
    .enableclk   (enableclk),
    .LEFTin      (LEFTin),
    .RIGHTin     (RIGHTin),
    .Ks          (Ks),
    .Kd          (Kd),
    .mono        (mono),
    .clr_overrun (clr_overrun),
    .SUMout      (SUMout),
    .DIFout      (DIFout),
    .valid_out   (valid_out),
    .clip_sum    (clip_sum),
    .clip_dif    (clip_dif),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // One-cycle strobe; optionally records the result due LAT edges later.
  task automatic pulse(input longint l, input longint r, input int ks, input int kd,
                       input bit m, input bit push,
                       input longint es, input longint ed, input bit ecs, input bit ecd);
    exp_t e;
    LEFTin    = NBITS'(l);
    RIGHTin   = NBITS'(r);
    Ks        = K_NBITS'(ks);
    Kd        = K_NBITS'(kd);
    mono      = m;
    enableclk = 1'b1;
    @(posedge clock);
    #1;
    enableclk = 1'b0;
    if (push) begin
      e.sum = es; e.dif = ed; e.cs = ecs; e.cd = ecd; e.cyc = cyc + LAT;
      sb.push_back(e);
    end
  endtask

  // Monitor: every valid_out must match the oldest expected result.
  always @(negedge clock) begin
    if (valid_out) begin
      if (sb.size() == 0) begin
        check("spurious_valid", valid_out, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("SUMout",    SUMout,   e.sum);
        check("DIFout",    DIFout,   e.dif);
        check("clip_sum",  clip_sum, e.cs);
        check("clip_dif",  clip_dif, e.cd);
        check("valid_cyc", cyc,      e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; enableclk = 1'b0; LEFTin = '0; RIGHTin = '0;
    Ks = '0; Kd = '0; mono = 1'b0; clr_overrun = 1'b0;
    gap(2);
    reset = 1'b0;
    check("rst_SUMout",  SUMout,    0);
    check("rst_DIFout",  DIFout,    0);
    check("rst_valid",   valid_out, 0);
    check("rst_busy",    busy,      0);
    check("rst_overrun", overrun,   0);
    gap(1);

    // Unity gain: 1200*8>>4 = 600, 800*8>>4 = 400; busy for exactly 5 cycles.
    pulse(1000, 200, 8, 8, 0, 1, 600, 400, 0, 0);
    for (int i = 0; i < 5; i++) begin
      check("busy_high", busy, 1);
      gap(1);
    end
    check("busy_low_at_valid", busy, 0);
    gap(2);

    // Positive saturation of the sum; difference is zero.
    pulse(131071, 131071, 15, 15, 0, 1, 131071, 0, 1, 0);
    gap(6);
    // Negative saturation.
    pulse(-131072, -131072, 15, 15, 0, 1, -131072, 0, 1, 0);
    gap(6);
    // Floor toward -inf: -3 >>> 4 = -1.
    pulse(-3, 0, 1, 1, 0, 1, -1, -1, 0, 0);
    gap(6);
    // Gain zero.
    pulse(1000, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    gap(6);

    // Overrun: strobes at t and t+2, then t+6 accepted while valid is high.
    check("overrun_before", overrun, 0);
    pulse(100, -50, 8, 4, 0, 1, 25, 37, 0, 0);        // 400>>4, 600>>4
    gap(1);
    pulse(7777, 1, 15, 15, 0, 0, 0, 0, 0, 0);          // ignored
    check("overrun_set", overrun, 1);
    gap(3);
    pulse(-1000, -1000, 12, 8, 0, 1, -1500, 0, 0, 0); // -24000>>4
    clr_overrun = 1'b1;                                // coincides with busy strobe
    pulse(4000, 4000, 15, 15, 0, 0, 0, 0, 0, 0);
    clr_overrun = 1'b0;
    check("overrun_set_wins", overrun, 1);
    gap(6);
    clr_overrun = 1'b1;
    gap(1);
    clr_overrun = 1'b0;
    check("overrun_cleared", overrun, 0);

    // Mono with input changes during MUL: S=0 only if L is held at capture.
    pulse(5000, -5000, 8, 8, 1, 1, 0, 0, 0, 0);
    LEFTin = '0;
    mono   = 1'b0;
    gap(6);

    // Reset mid-operation after a nonzero result and with overrun set.
    pulse(1000, 200, 8, 8, 0, 1, 600, 400, 0, 0);
    gap(6);
    pulse(2000, 0, 8, 8, 0, 0, 0, 0, 0, 0);            // will be discarded
    gap(1);
    pulse(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);               // busy strobe sets overrun
    #3 reset = 1'b1;
    #1;
    check("midrst_SUMout",  SUMout,    0);
    check("midrst_DIFout",  DIFout,    0);
    check("midrst_clips",   {clip_sum, clip_dif}, 0);
    check("midrst_valid",   valid_out, 0);
    check("midrst_busy",    busy,      0);
    check("midrst_overrun", overrun,   0);
    @(posedge clock);
    #3 reset = 1'b0;
    gap(10);
    pulse(1000, 200, 8, 8, 0, 1, 600, 400, 0, 0);
    gap(7);

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(posedge clock);
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
